// File: rtl/spi_wb_bridge_if.sv
// Wishbone master-side bundle for the SPI-to-Wishbone bridge.
// The bridge drives the master modport; a bus slave uses the slave modport.
interface spi_wb_bridge_if;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_o;
    logic        wb_we_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o,
        output wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o,
        input  wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i
    );
endinterface

// File: rtl/spi_wb_bridge.sv
// SPI mode-0 responder that issues one 32-bit Wishbone access per frame.
// SCK/CS/MOSI are oversampled on clk; read data returns after 8 turnaround bits.
module spi_wb_bridge #(
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] ERR_WORD = 32'hDEADBEEF
) (
    input  logic clk,
    input  logic rst,
    input  logic spi_sck,
    input  logic spi_cs_n,
    input  logic spi_mosi,
    output logic spi_miso,
    spi_wb_bridge_if.master wb,
    output logic busy,
    output logic err
);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CMD, S_ADDR, S_WDATA,
        S_WB_REQ, S_TURN, S_RDATA, S_DONE
    } state_t;

    state_t       r_state, w_next;
    logic [1:0]   r_sck_s, r_cs_s, r_mosi_s;
    logic         r_sck_d, r_cs_d;
    logic [5:0]   r_cnt;
    logic [31:0]  r_sr;
    logic [29:0]  r_adr;
    logic         r_we, r_cyc, r_issued, r_miso, r_err;
    logic [TMO_W-1:0] r_tmo;

    logic w_sck, w_cs_n, w_mosi;
    logic w_rise, w_fall, w_cs_fall;
    logic w_shift, w_issue, w_rd_open, w_to_rdata;
    logic w_ack, w_tmo;

    assign w_sck     = r_sck_s[1];
    assign w_cs_n    = r_cs_s[1];
    assign w_mosi    = r_mosi_s[1];
    assign w_rise    = w_sck & ~r_sck_d;
    assign w_fall    = ~w_sck & r_sck_d;
    assign w_cs_fall = r_cs_d & ~w_cs_n;
    assign w_ack     = r_cyc & wb.wb_ack_i;
    assign w_tmo     = r_cyc & ~wb.wb_ack_i
                     & (r_tmo == TMO_W'(TIMEOUT - 1));

    // Two-flop synchronizers plus previous-value flops for edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sck_s  <= 2'b00;
            r_cs_s   <= 2'b11;
            r_mosi_s <= 2'b00;
            r_sck_d  <= 1'b0;
            r_cs_d   <= 1'b1;
        end else begin
            r_sck_s  <= {r_sck_s[0], spi_sck};
            r_cs_s   <= {r_cs_s[0], spi_cs_n};
            r_mosi_s <= {r_mosi_s[0], spi_mosi};
            r_sck_d  <= w_sck;
            r_cs_d   <= w_cs_n;
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_next;
    end

    // Frame sequencing; read turnaround keeps counting while the bus cycle runs
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:   if (w_cs_fall) w_next = S_CMD;
            S_CMD:    if (w_cs_n) w_next = S_IDLE;
                      else if (w_rise && r_cnt == 6'd7) w_next = S_ADDR;
            S_ADDR:   if (w_cs_n) w_next = S_IDLE;
                      else if (w_rise && r_cnt == 6'd31)
                          w_next = r_we ? S_WDATA : S_WB_REQ;
            S_WDATA:  if (w_cs_n) w_next = S_IDLE;
                      else if (w_rise && r_cnt == 6'd31) w_next = S_WB_REQ;
            S_WB_REQ: if (r_issued) begin
                          if (!r_we)      w_next = S_TURN;
                          else if (!r_cyc) w_next = S_DONE;
                      end
            S_TURN:   if (w_cs_n) w_next = S_DONE;
                      else if (w_rise && r_cnt == 6'd7) w_next = S_RDATA;
            S_RDATA:  if (w_cs_n) w_next = S_DONE;
                      else if (w_rise && r_cnt == 6'd31) w_next = S_DONE;
            S_DONE:   if (w_cs_n && !r_cyc) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Per-state control strobes for the datapath
    always_comb begin
        w_shift    = w_rise && (r_state inside {S_CMD, S_ADDR, S_WDATA});
        w_issue    = (r_state == S_WB_REQ) && !r_issued;
        w_rd_open  = r_state inside {S_WB_REQ, S_TURN};
        w_to_rdata = (r_state == S_TURN) && (w_next == S_RDATA);
    end

    // Bit counter restarts per field; WB_REQ -> TURN keeps the turnaround count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_cnt <= '0;
        else if (r_state != w_next && r_state != S_WB_REQ)
            r_cnt <= '0;
        else if (w_rise)
            r_cnt <= r_cnt + 6'd1;
    end

    // Shift register: MOSI in, read data or error word loaded, MISO out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_sr <= '0;
        else if (w_shift)
            r_sr <= {r_sr[30:0], w_mosi};
        else if (w_ack && !r_we && w_rd_open)
            r_sr <= wb.wb_dat_i;
        else if ((w_tmo && !r_we && w_rd_open) || (w_to_rdata && r_cyc))
            r_sr <= ERR_WORD;
        else if (r_state == S_RDATA && w_fall)
            r_sr <= {r_sr[30:0], 1'b0};
    end

    // Command direction and word address capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we  <= 1'b0;
            r_adr <= '0;
        end else begin
            if (w_rise && r_state == S_CMD && r_cnt == 6'd0)
                r_we <= w_mosi;
            if (w_rise && r_state == S_ADDR && r_cnt == 6'd31)
                r_adr <= r_sr[30:1];
        end
    end

    // Single Wishbone cycle with timeout watchdog
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cyc    <= 1'b0;
            r_issued <= 1'b0;
            r_tmo    <= '0;
        end else begin
            if (r_state == S_IDLE) r_issued <= 1'b0;
            else if (w_issue)      r_issued <= 1'b1;
            if (w_issue) begin
                r_cyc <= 1'b1;
                r_tmo <= '0;
            end else if (w_ack || w_tmo) begin
                r_cyc <= 1'b0;
            end else if (r_cyc) begin
                r_tmo <= r_tmo + 1'b1;
            end
        end
    end

    // MISO changes on SCK falling edges only while shifting read data
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                   r_miso <= 1'b0;
        else if (r_state != S_RDATA) r_miso <= 1'b0;
        else if (w_fall)            r_miso <= r_sr[31];
    end

    // Sticky error: timeout or read data not ready at RDATA start
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_err <= 1'b0;
        else if (r_state == S_IDLE && w_cs_fall)
            r_err <= 1'b0;
        else if (w_tmo || (w_to_rdata && r_cyc && !wb.wb_ack_i))
            r_err <= 1'b1;
    end

    assign wb.wb_cyc_o = r_cyc;
    assign wb.wb_stb_o = r_cyc;
    assign wb.wb_sel_o = {4{r_cyc}};
    assign wb.wb_we_o  = r_cyc & r_we;
    assign wb.wb_adr_o = r_cyc ? {r_adr, 2'b00} : 32'h0;
    assign wb.wb_dat_o = (r_cyc && r_we) ? r_sr : 32'h0;
    assign spi_miso    = r_miso;
    assign busy        = ~w_cs_n | r_cyc;
    assign err         = r_err;
endmodule

// File: tb/tb_spi_wb_bridge.sv
// Bench for spi_wb_bridge: bit-banged SPI initiator, Wishbone slave memory,
// vector table, random frames against a memory-level reference model.
module tb_spi_wb_bridge;
    localparam int          H   = 5;
    localparam logic [31:0] ERR = 32'hDEADBEEF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic spi_sck = 1'b0, spi_cs_n = 1'b1, spi_mosi = 1'b0;
    logic spi_miso, busy, err;

    spi_wb_bridge_if bus ();

    spi_wb_bridge dut (
        .clk(clk), .rst(rst),
        .spi_sck(spi_sck), .spi_cs_n(spi_cs_n),
        .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .wb(bus), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_err = 0;
    int s_dly = 0;
    int n_cyc = 0, stb_bad = 0, s_cnt = 0;
    logic cyc_prev = 1'b0;
    logic [31:0] l_adr, l_dat;
    logic l_we;
    logic [3:0] l_sel;
    logic [31:0] slv_mem [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];

    typedef struct {
        bit          we;
        logic [31:0] adr;
        logic [31:0] dat;
        int          dly;
        logic [31:0] e_adr;
        logic [31:0] e_rd;
        bit          e_err;
    } vec_t;

    // Wishbone slave: acks s_dly clocks into a cycle (never if negative)
    always @(negedge clk) begin
        if (bus.wb_cyc_o && !cyc_prev) begin
            n_cyc++;
            l_adr = bus.wb_adr_o;
            l_dat = bus.wb_dat_o;
            l_we  = bus.wb_we_o;
            l_sel = bus.wb_sel_o;
            s_cnt = 0;
        end
        if (bus.wb_stb_o !== bus.wb_cyc_o) stb_bad++;
        if (bus.wb_ack_i === 1'b1) begin
            bus.wb_ack_i = 1'b0;
        end else if (bus.wb_cyc_o) begin
            if (s_dly >= 0 && s_cnt == s_dly) begin
                bus.wb_ack_i = 1'b1;
                if (bus.wb_we_o)
                    slv_mem[bus.wb_adr_o] = bus.wb_dat_o;
                else if (slv_mem.exists(bus.wb_adr_o))
                    bus.wb_dat_i = slv_mem[bus.wb_adr_o];
                else
                    bus.wb_dat_i = bus.wb_adr_o ^ 32'h5A5A5A5A;
            end
            s_cnt++;
        end else begin
            bus.wb_ack_i = 1'b0;
            bus.wb_dat_i = 32'h0;
        end
        cyc_prev = bus.wb_cyc_o;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic spi_frame(input bit we, input logic [31:0] adr,
                             input logic [31:0] dat, input int extra,
                             input int stop, output logic [31:0] rd);
        logic [79:0] mv;
        int n;
        mv = {we, 7'd0, adr, (we ? dat : 32'd0), 8'd0};
        n  = we ? 72 : 80;
        if (stop > 0) n = stop;
        rd = '0;
        @(negedge clk);
        spi_cs_n = 1'b0;
        repeat (H) @(negedge clk);
        for (int k = 0; k < n + extra; k++) begin
            spi_mosi = (k < n) ? mv[79-k] : 1'($urandom);
            spi_sck  = 1'b0;
            repeat (H) @(negedge clk);
            if (!we && stop == 0 && k >= 48 && k < 80)
                rd[79-k] = spi_miso;
            spi_sck = 1'b1;
            repeat (H) @(negedge clk);
        end
        spi_sck  = 1'b0;
        spi_mosi = 1'b0;
        repeat (H) @(negedge clk);
        spi_cs_n = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int i;
        i = 0;
        while (busy && i < 400) begin
            @(negedge clk);
            i++;
        end
        chk({tag, "_idle"}, 32'(busy), 32'h0);
        chk({tag, "_miso0"}, 32'(spi_miso), 32'h0);
        repeat (3) @(negedge clk);
    endtask

    task automatic run_vec(input string tag, input bit we,
                           input logic [31:0] adr, input logic [31:0] dat,
                           input int dly, input int extra,
                           input logic [31:0] e_adr, input logic [31:0] e_rd,
                           input bit e_err);
        int c0;
        logic [31:0] rd;
        s_dly = dly;
        c0 = n_cyc;
        spi_frame(we, adr, dat, extra, 0, rd);
        wait_idle(tag);
        chk({tag, "_ncyc"}, 32'(n_cyc - c0), 32'd1);
        chk({tag, "_adr"}, l_adr, e_adr);
        chk({tag, "_we"}, 32'(l_we), 32'(we));
        chk({tag, "_sel"}, 32'(l_sel), 32'hF);
        if (we) chk({tag, "_wdat"}, l_dat, dat);
        else    chk({tag, "_rdat"}, rd, e_rd);
        chk({tag, "_err"}, 32'(err), 32'(e_err));
        if (we && dly >= 0) ref_mem[e_adr] = dat;
    endtask

    initial begin
        vec_t tbl [9];
        logic [31:0] rd;
        int c0;

        tbl[0] = '{1'b1, 32'h40000000, 32'h000000A5, 2, 32'h40000000, 32'h0, 1'b0};
        tbl[1] = '{1'b1, 32'h20000004, 32'h12345678, 1, 32'h20000004, 32'h0, 1'b0};
        tbl[2] = '{1'b0, 32'h20000004, 32'h0, 3, 32'h20000004, 32'h12345678, 1'b0};
        tbl[3] = '{1'b0, 32'h30000000, 32'h0, -1, 32'h30000000, ERR, 1'b1};
        tbl[4] = '{1'b1, 32'h20000003, 32'hCAFEF00D, 0, 32'h20000000, 32'h0, 1'b0};
        tbl[5] = '{1'b0, 32'h20000001, 32'h0, 1, 32'h20000000, 32'hCAFEF00D, 1'b0};
        tbl[6] = '{1'b0, 32'h40000000, 32'h0, 5, 32'h40000000, 32'h000000A5, 1'b0};
        tbl[7] = '{1'b1, 32'h10000010, 32'hFFFFFFFF, -1, 32'h10000010, 32'h0, 1'b1};
        tbl[8] = '{1'b0, 32'h10000010, 32'h0, 0, 32'h10000010, 32'h4A5A5A4A, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_ctl", {25'd0, spi_miso, busy, err, bus.wb_cyc_o,
                        bus.wb_stb_o, bus.wb_we_o, |bus.wb_sel_o}, 32'h0);
        chk("rst_adr", bus.wb_adr_o, 32'h0);
        chk("rst_dat", bus.wb_dat_o, 32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_vec($sformatf("vec%0d", i), tbl[i].we, tbl[i].adr,
                    tbl[i].dat, tbl[i].dly, 0, tbl[i].e_adr,
                    tbl[i].e_rd, tbl[i].e_err);

        for (int i = 0; i < 30; i++) begin
            bit we;
            logic [31:0] a, d, ea, er;
            int dly;
            we  = 1'($urandom_range(0, 1));
            a   = 32'h40000000 | 32'($urandom_range(0, 31));
            d   = $urandom;
            dly = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 6));
            ea  = a & ~32'h3;
            if (dly < 0)               er = ERR;
            else if (ref_mem.exists(ea)) er = ref_mem[ea];
            else                       er = ea ^ 32'h5A5A5A5A;
            run_vec($sformatf("rnd%0d", i), we, a, d, dly, 0, ea, er, dly < 0);
        end

        s_dly = 0;
        c0 = n_cyc;
        spi_frame(1'b1, 32'h40000008, 32'h11111111, 0, 20, rd);
        wait_idle("abort");
        chk("abort_ncyc", 32'(n_cyc - c0), 32'd0);
        run_vec("after_abort", 1'b1, 32'h40000008, 32'h22222222, 0, 0,
                32'h40000008, 32'h0, 1'b0);
        run_vec("after_abort_rd", 1'b0, 32'h40000008, 32'h0, 2, 0,
                32'h40000008, 32'h22222222, 1'b0);

        run_vec("extra_sck", 1'b1, 32'h20000003, 32'h0BADF00D, 2, 16,
                32'h20000000, 32'h0, 1'b0);

        s_dly = -1;
        spi_frame(1'b1, 32'h40000010, 32'h33333333, 0, 0, rd);
        chk("rst_pre_cyc", 32'(bus.wb_cyc_o), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("arst_ctl", {25'd0, spi_miso, busy, err, bus.wb_cyc_o,
                         bus.wb_stb_o, bus.wb_we_o, |bus.wb_sel_o}, 32'h0);
        chk("arst_adr", bus.wb_adr_o, 32'h0);
        chk("arst_dat", bus.wb_dat_o, 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        run_vec("post_rst", 1'b1, 32'h40000010, 32'h44444444, 1, 0,
                32'h40000010, 32'h0, 1'b0);
        run_vec("post_rst_rd", 1'b0, 32'h40000010, 32'h0, 2, 0,
                32'h40000010, 32'h44444444, 1'b0);

        chk("stb_eq_cyc", 32'(stb_bad), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
